axi_aw_arb3: RTL and testbench

Three-port AXI write arbiter placed between the three traffic masters (axi0/axi1/axi2) and the single DDR3 controller write port. It arbitrates the AW channel under the `arb_en` / `arb_mode` / `WEIGHT_SETTINGn` register fields of `ddr3_reg`. It then routes each W burst from the port whose AW was granted. Its AW behaviour is what the `axi_sva` checker asserts.

---
 rtl/axi_arb_pkg.sv | 23 ++
 rtl/axi_arb_route_fifo.sv | 59 +++++
 rtl/axi_aw_arb3.sv | 198 +++++++++++++++++++
 tb/tb_axi_aw_arb3.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types for the three-port AXI AW arbiter.
//   arb_mode_e  : arbitration policy encoding of the arb_mode register field
//   NPORT       : number of upstream masters
//   port_idx_t  : index of an upstream port (also the W-route FIFO payload)
//   next_port() : round-robin successor of a port index
package axi_arb_pkg;

  localparam int NPORT = 3;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    ARB_FIXED = 2'd0,
    ARB_RR    = 2'd1,
    ARB_WRR   = 2'd2,
    ARB_RSVD  = 2'd3
  } arb_mode_e;

  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(NPORT - 1)) ? port_idx_t'(0) : p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/axi_arb_route_fifo.sv
// Synchronous FIFO holding the port index of every granted AW, so that W
// bursts are routed in AW grant order.
//   clk, rst       : clock, asynchronous active-high reset
//   push/push_data : enqueue a port index (ignored when full)
//   pop            : dequeue the head entry (ignored when empty)
//   head           : current head entry (meaningless while empty)
//   full, empty    : flags derived from the registered occupancy count
module axi_arb_route_fifo
  import axi_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  port_idx_t push_data,
  input  logic      pop,
  output port_idx_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  port_idx_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_aw_arb3.sv
// Three-port AXI write arbiter in front of the DDR3 controller write port.
// Arbitrates AW (fixed / round robin / weighted round robin), registers the
// winner into a single-entry AW output stage and routes each W burst from the
// port whose AW was granted, in grant order.
//
// Handshakes: a transfer happens on a rising aclk edge where valid and ready
// are both high; a source holds valid and payload stable until that edge, and
// ready may depend combinationally on valid.
//
// Ports:
//   aclk, areset                 : clock, asynchronous active-high reset
//   arb_en, arb_mode, weight0..2 : arbitration control (sampled every cycle)
//   s_aw* / s_awready            : per-port AW, port n in slice/bit n
//   m_aw*                        : downstream AW (registered)
//   s_w* / s_wready              : per-port W, port n in slice/bit n
//   m_w*                         : downstream W (combinational from route head)
//   stat_gnt                     : per-port grant counters, only when the
//                                  AXI_ARB_STAT_EN macro is defined
module axi_aw_arb3
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ID_W        = 4,
  parameter int DATA_W      = 64,
  parameter int ROUTE_DEPTH = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    arb_en,
  input  logic [1:0]              arb_mode,
  input  logic [15:0]             weight0,
  input  logic [15:0]             weight1,
  input  logic [15:0]             weight2,
  input  logic [NPORT-1:0]        s_awvalid,
  output logic [NPORT-1:0]        s_awready,
  input  logic [NPORT*ADDR_W-1:0] s_awaddr,
  input  logic [NPORT*ID_W-1:0]   s_awid,
  input  logic [NPORT*8-1:0]      s_awlen,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_W-1:0]       m_awaddr,
  output logic [ID_W-1:0]         m_awid,
  output logic [7:0]              m_awlen,
  input  logic [NPORT-1:0]        s_wvalid,
  output logic [NPORT-1:0]        s_wready,
  input  logic [NPORT-1:0]        s_wlast,
  input  logic [NPORT*DATA_W-1:0] s_wdata,
  input  logic [NPORT*DATA_W/8-1:0] s_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic                    m_wlast,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb
`ifdef AXI_ARB_STAT_EN
  ,
  output logic [NPORT*32-1:0]     stat_gnt
`endif
);

  // First requesting port found scanning upward (with wrap) from start.
  function automatic port_idx_t pick(input logic [NPORT-1:0] v, input port_idx_t start);
    port_idx_t p;
    logic      found;
    pick  = start;
    p     = start;
    found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (!found && v[p]) begin
        pick  = p;
        found = 1'b1;
      end
      p = next_port(p);
    end
  endfunction

  arb_mode_e        mode;
  logic [NPORT-1:0] elig;
  logic             ld;
  logic             gnt;
  logic             route_full;
  logic             route_empty;
  logic             w_pop;
  port_idx_t        last;
  port_idx_t        run_owner;
  logic [15:0]      run_cnt;
  logic [15:0]      w_own;
  port_idx_t        start;
  port_idx_t        win;
  port_idx_t        head;

  assign mode = arb_mode_e'(arb_mode);

  always_comb begin
    elig = arb_en ? s_awvalid : {{(NPORT-1){1'b0}}, s_awvalid[0]};

    case (run_owner)
      2'd0:    w_own = weight0;
      2'd1:    w_own = weight1;
      default: w_own = weight2;
    endcase
    if (w_own == 16'd0) w_own = 16'd1;

    // In WRR the owner keeps first priority until its run is used up; if it
    // is then the only requester, the scan from owner+1 wraps back to it.
    case (mode)
      ARB_FIXED: start = '0;
      ARB_WRR:   start = (run_cnt < w_own) ? run_owner : next_port(run_owner);
      default:   start = next_port(last);
    endcase

    win = pick(elig, start);
  end

  // route_full is registered-count based, so a pop in the same cycle does not
  // free a slot for a push.
  assign ld        = (!m_awvalid || m_awready) && !route_full;
  assign gnt       = ld && (|elig) && !areset;
  assign s_awready = gnt ? (NPORT'(1) << win) : '0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awid    <= '0;
      m_awlen   <= '0;
      last      <= port_idx_t'(NPORT - 1);
      run_owner <= '0;
      run_cnt   <= '0;
    end else begin
      if (gnt) begin
        m_awvalid <= 1'b1;
        m_awaddr  <= s_awaddr[int'(win)*ADDR_W +: ADDR_W];
        m_awid    <= s_awid[int'(win)*ID_W +: ID_W];
        m_awlen   <= s_awlen[int'(win)*8 +: 8];
        last      <= win;
        if (win == run_owner) begin
          if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
        end else begin
          run_owner <= win;
          run_cnt   <= 16'd1;
        end
      end else if (m_awready) begin
        m_awvalid <= 1'b0;
      end
    end
  end

  axi_arb_route_fifo #(
    .DEPTH(ROUTE_DEPTH)
  ) u_route (
    .clk       (aclk),
    .rst       (areset),
    .push      (gnt),
    .push_data (win),
    .pop       (w_pop),
    .head      (head),
    .full      (route_full),
    .empty     (route_empty)
  );

  // W pass-through from the port at the route head; everything idle when empty.
  always_comb begin
    m_wvalid = 1'b0;
    m_wlast  = 1'b0;
    m_wdata  = '0;
    m_wstrb  = '0;
    s_wready = '0;
    if (!route_empty) begin
      m_wvalid       = s_wvalid[head];
      m_wlast        = s_wlast[head];
      m_wdata        = s_wdata[int'(head)*DATA_W +: DATA_W];
      m_wstrb        = s_wstrb[int'(head)*(DATA_W/8) +: DATA_W/8];
      s_wready[head] = m_wready;
    end
  end

  assign w_pop = m_wvalid && m_wready && m_wlast;

`ifdef AXI_ARB_STAT_EN
  logic [31:0] gnt_cnt [NPORT];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int p = 0; p < NPORT; p++) gnt_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (gnt && (win == port_idx_t'(p)) && (gnt_cnt[p] != 32'hFFFF_FFFF))
          gnt_cnt[p] <= gnt_cnt[p] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) stat_gnt[p*32 +: 32] = gnt_cnt[p];
  end
`endif

endmodule

// File: tb/tb_axi_aw_arb3.sv
module tb_axi_aw_arb3;

  localparam int ADDR_W      = 32;
  localparam int ID_W        = 4;
  localparam int DATA_W      = 64;
  localparam int ROUTE_DEPTH = 4;
  localparam int PW          = ADDR_W + ID_W + 8;

  logic                  aclk = 1'b0;
  logic                  areset;
  logic                  arb_en;
  logic [1:0]            arb_mode;
  logic [15:0]           weight0, weight1, weight2;
  logic [2:0]            s_awvalid, s_awready;
  logic [3*ADDR_W-1:0]   s_awaddr;
  logic [3*ID_W-1:0]     s_awid;
  logic [3*8-1:0]        s_awlen;
  logic                  m_awvalid, m_awready;
  logic [ADDR_W-1:0]     m_awaddr;
  logic [ID_W-1:0]       m_awid;
  logic [7:0]            m_awlen;
  logic [2:0]            s_wvalid, s_wready, s_wlast;
  logic [3*DATA_W-1:0]   s_wdata;
  logic [3*DATA_W/8-1:0] s_wstrb;
  logic                  m_wvalid, m_wready, m_wlast;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
`ifdef AXI_ARB_STAT_EN
  logic [3*32-1:0]       stat_gnt;
`endif

  axi_aw_arb3 #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .ROUTE_DEPTH(ROUTE_DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset), .arb_en(arb_en), .arb_mode(arb_mode),
    .weight0(weight0), .weight1(weight1), .weight2(weight2),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awlen(s_awlen),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awid(m_awid), .m_awlen(m_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb)
`ifdef AXI_ARB_STAT_EN
    , .stat_gnt(stat_gnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  // ---------------- scoreboard state ----------------
  logic [PW-1:0]       exp_q[$];
  logic [1:0]          wexp_q[$];
  int                  serial [3];
  logic [DATA_W-1:0]   wdat [3];
  logic [DATA_W/8-1:0] wstb [3];
  int                  n_vec = 0;
  int                  n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] aw_word(input int p, input int s);
    logic [ADDR_W-1:0] a;
    logic [ID_W-1:0]   id;
    logic [7:0]        len;
    a   = {4'(p), 28'(s)};
    id  = {2'(s), 2'(p)};
    len = 8'(s * 3 + p);
    return {a, id, len};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_aw();
    logic [PW-1:0] w;
    for (int p = 0; p < 3; p++) begin
      w = aw_word(p, serial[p]);
      s_awaddr[p*ADDR_W +: ADDR_W] = w[PW-1 -: ADDR_W];
      s_awid[p*ID_W +: ID_W]       = w[8 +: ID_W];
      s_awlen[p*8 +: 8]            = w[7:0];
    end
  endtask

  task automatic set_cfg(input logic en, input logic [1:0] mode, input int w0,
                         input int w1, input int w2, input logic [2:0] v);
    arb_en    = en;
    arb_mode  = mode;
    weight0   = 16'(w0);
    weight1   = 16'(w1);
    weight2   = 16'(w2);
    s_awvalid = v;
  endtask

  // One arbitration cycle: exp is the port expected to be granted, -1 = none.
  task automatic aw_cycle(input int exp);
    logic [2:0] hs;
    logic [2:0] want;
    @(negedge aclk);
    want = (exp >= 0) ? (3'b001 << exp) : 3'b000;
    check("s_awready", 64'(s_awready), 64'(want));
    if (exp >= 0) begin
      exp_q.push_back(aw_word(exp, serial[exp]));
      wexp_q.push_back(2'(exp));
    end
    hs = s_awvalid & s_awready;
    @(posedge aclk);
    #1;
    for (int p = 0; p < 3; p++) if (hs[p]) serial[p]++;
    drive_aw();
  endtask

  task automatic do_reset();
    s_awvalid = 3'b000;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    areset    = 1'b1;
    exp_q.delete();
    wexp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic drain();
    s_awvalid = 3'b000;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || wexp_q.size() != 0); i++)
      @(posedge aclk);
    @(posedge aclk);
    #1;
    check("drain_aw", 64'(exp_q.size()), 64'(0));
    check("drain_w", 64'(wexp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_awvalid"}, 64'(m_awvalid), 64'(0));
    check({tag, "_m_awaddr"}, 64'(m_awaddr), 64'(0));
    check({tag, "_m_awid"}, 64'(m_awid), 64'(0));
    check({tag, "_m_awlen"}, 64'(m_awlen), 64'(0));
    check({tag, "_s_awready"}, 64'(s_awready), 64'(0));
    check({tag, "_s_wready"}, 64'(s_wready), 64'(0));
    check({tag, "_m_wvalid"}, 64'(m_wvalid), 64'(0));
`ifdef AXI_ARB_STAT_EN
    check({tag, "_stat_gnt"}, 64'(|stat_gnt), 64'(0));
`endif
  endtask

  // ---------------- output monitors ----------------
  always @(negedge aclk) begin
    if (!areset && m_awvalid && m_awready) begin
      logic [PW-1:0] e;
      check("aw_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_awaddr", 64'(m_awaddr), 64'(e[PW-1 -: ADDR_W]));
        check("m_awid", 64'(m_awid), 64'(e[8 +: ID_W]));
        check("m_awlen", 64'(m_awlen), 64'(e[7:0]));
      end
    end
  end

  always @(negedge aclk) begin
    if (!areset && m_wvalid && m_wready) begin
      logic [1:0] wp;
      check("w_expected", 64'(wexp_q.size() != 0), 64'(1));
      if (wexp_q.size() != 0) begin
        wp = wexp_q[0];
        check("m_wdata", 64'(m_wdata), 64'(wdat[wp]));
        check("m_wstrb", 64'(m_wstrb), 64'(wstb[wp]));
        check("s_wready", 64'(s_wready), 64'(3'b001 << wp));
        if (m_wlast) void'(wexp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int  nxt;
    logic pend;
    logic grant;

    for (int p = 0; p < 3; p++) begin
      serial[p] = p * 16;
      wdat[p]   = {$urandom, $urandom};
      wstb[p]   = {4'(p + 1), 4'hA};
      s_wdata[p*DATA_W +: DATA_W]         = wdat[p];
      s_wstrb[p*(DATA_W/8) +: DATA_W/8]   = wstb[p];
    end
    s_wvalid  = 3'b111;
    s_wlast   = 3'b111;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    areset    = 1'b1;
    set_cfg(1'b1, 2'd1, 1, 1, 1, 3'b111);
    drive_aw();
    #2;
    check_reset_outputs("por");
    do_reset();

    // Fixed priority: port 0 dominates, then 1, then 2.
    set_cfg(1'b1, 2'd0, 1, 1, 1, 3'b111);
    for (int i = 0; i < 6; i++) aw_cycle(0);
    s_awvalid = 3'b110;
    aw_cycle(1);
    aw_cycle(1);
    s_awvalid = 3'b100;
    aw_cycle(2);
    drain();
`ifdef AXI_ARB_STAT_EN
    check("stat_gnt0", 64'(stat_gnt[31:0]), 64'(6));
    check("stat_gnt1", 64'(stat_gnt[63:32]), 64'(2));
    check("stat_gnt2", 64'(stat_gnt[95:64]), 64'(1));
`endif

    // Round robin, then a subset of requesters.
    do_reset();
    set_cfg(1'b1, 2'd1, 1, 1, 1, 3'b111);
    for (int i = 0; i < 6; i++) aw_cycle(i % 3);
    s_awvalid = 3'b101;
    aw_cycle(0);
    aw_cycle(2);
    aw_cycle(0);
    drain();

    // Reserved mode behaves as round robin.
    do_reset();
    set_cfg(1'b1, 2'd3, 1, 1, 1, 3'b111);
    for (int i = 0; i < 4; i++) aw_cycle(i % 3);
    drain();

    // Weighted RR, weights 3/1/2.
    do_reset();
    set_cfg(1'b1, 2'd2, 3, 1, 2, 3'b111);
    aw_cycle(0); aw_cycle(0); aw_cycle(0);
    aw_cycle(1);
    aw_cycle(2); aw_cycle(2);
    aw_cycle(0); aw_cycle(0); aw_cycle(0);
    drain();

    // Weighted RR with zero weights acts as weight 1.
    do_reset();
    set_cfg(1'b1, 2'd2, 0, 0, 0, 3'b111);
    for (int i = 0; i < 6; i++) aw_cycle(i % 3);
    drain();

    // arb_en=0: ports 1/2 starve, port 0 granted as soon as it asks.
    do_reset();
    set_cfg(1'b0, 2'd1, 1, 1, 1, 3'b110);
    for (int i = 0; i < 10; i++) aw_cycle(-1);
    s_awvalid = 3'b111;
    aw_cycle(0);
    aw_cycle(0);
    aw_cycle(0);
    drain();

    // Random downstream AW backpressure, round robin.
    do_reset();
    set_cfg(1'b1, 2'd1, 1, 1, 1, 3'b111);
    nxt  = 0;
    pend = 1'b0;
    for (int i = 0; i < 24; i++) begin
      m_awready = 1'($urandom_range(0, 1));
      grant = !pend || m_awready;
      if (grant) begin
        aw_cycle(nxt);
        nxt = (nxt + 1) % 3;
      end else begin
        aw_cycle(-1);
      end
      pend = grant || (pend && !m_awready);
    end
    drain();

    // Route FIFO full stalls AW; first wlast pop frees a slot.
    do_reset();
    set_cfg(1'b1, 2'd1, 1, 1, 1, 3'b111);
    m_wready = 1'b0;
    aw_cycle(0); aw_cycle(1); aw_cycle(2); aw_cycle(0);
    aw_cycle(-1); aw_cycle(-1); aw_cycle(-1);
    m_wready = 1'b1;
    aw_cycle(-1);
    aw_cycle(1);
    aw_cycle(2);
    aw_cycle(0);
    drain();

    // Asynchronous reset mid-burst.
    do_reset();
    set_cfg(1'b1, 2'd1, 1, 1, 1, 3'b111);
    m_wready = 1'b0;
    aw_cycle(0);
    aw_cycle(1);
    #2;
    areset = 1'b1;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    wexp_q.delete();
    @(posedge aclk);
    #1;
    areset   = 1'b0;
    m_wready = 1'b1;
    aw_cycle(0);
    aw_cycle(1);
    aw_cycle(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
